bcd_seq_conv: RTL and testbench
===============================

# bcd_seq_conv

Multi-cycle, parametrised binary-to-BCD converter using an iterative shift-and-add-3 algorithm. It processes one input bit per clock and uses a valid/ready handshake on both input and output. It replaces the combinational converter in the calculator display datapath, which at 36 bits produces a long add-3 chain. Width and digit count are generic, results that do not fit are flagged as overflow, and two's-complement input is an optional build feature.

## Interface
- BIN_W, 36: binary operand width; legal range 2..64.
- DIGITS, 11: number of BCD digits produced; legal range 1..20.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand valid.
- in_ready  out  1  converter can accept an operand.
- in_bin  in  BIN_W  operand.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_bcd  out  4*DIGITS  result digits; digit k is [4k+3:4k]; digit 0 is the ones digit.
- out_ovf  out  1  the value did not fit in DIGITS digits.
- out_neg  out  1  the operand was negative (signed build only).

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - SHIFT: iterating.
  - DONE: out_valid=1.
- IDLE -> SHIFT on in_valid && in_ready.
  - Capture the operand into a shift register and clear the digit register, out_ovf and the bit counter.
- Each SHIFT cycle performs one iteration:
  - every digit ≥5 gets +3 (4-bit wrap);
  - the concatenation {digits, operand} shifts left by 1;
  - if bit 3 of the top digit was 1 before the shift, set sticky ovf.
- SHIFT -> DONE after exactly BIN_W iterations (counter width $clog2(BIN_W+1)).
- DONE -> IDLE on out_ready. out_bcd, out_ovf and out_neg hold stable while out_valid && !out_ready.
- Overflow result: out_bcd = value mod 10^DIGITS and out_ovf=1.
- No overflow is possible when 10^DIGITS ≥ 2^BIN_W (true for the defaults).
- in_ready is 0 outside IDLE. in_valid during SHIFT/DONE is ignored; the operand is not queued.
- Reset on any cycle, including mid-SHIFT or in DONE: the FSM goes to IDLE and the in-flight conversion is discarded.
- Reset values: in_ready=1 after reset (0 while rst_n=0); out_valid=0; out_bcd=0; out_ovf=0; out_neg=0.

## Timing
- Acceptance edge E0. Iterations occur on E1..E_BIN_W. out_valid goes high after E_BIN_W.
- Latency from acceptance edge to out_valid: BIN_W cycles (36 at defaults).
- The output handshake completes on the edge where out_valid && out_ready. in_ready rises on that same edge.
- The next operand can be accepted at the following edge.
- Throughput: one conversion per BIN_W+2 cycles with out_ready held at 1.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- BCD_SIGNED_EN defined:
  - in_bin is two's-complement.
  - On accept: out_neg = in_bin[BIN_W-1], and the magnitude (negated if negative) is loaded.
  - The magnitude of -2^(BIN_W-1) fits in BIN_W bits unsigned and needs no special case.
- BCD_SIGNED_EN undefined:
  - in_bin is unsigned.
  - out_neg is tied to 0.
  - The negation logic is absent.
- Latency is identical in both builds.

## Structure
- Package bcd_pkg holds:
  - the FSM state enum (IDLE, SHIFT, DONE);
  - the typedef for a 4-bit BCD digit;
  - the function digits_needed(width), returning the minimum DIGITS with no overflow. Benches use it for checks.
- Sub-module bcd_add3_cell: combinational, 4-bit input and output, adds 3 when the input is ≥5. Generated once per digit.
- The top level owns the FSM, bit counter, shift register and handshake.

## Test plan
- Defaults, in_bin=0 -> out_valid 36 cycles after acceptance; out_bcd all zeros; out_ovf=0.
- Defaults, in_bin=2^36-1 -> digits 6,8,7,1,9,4,7,6,7,3,5 (68719476735); out_ovf=0.
- BIN_W=8, DIGITS=2, in_bin=255 -> out_bcd=0x55, out_ovf=1. Then in_bin=99 -> out_bcd=0x99, out_ovf=0 (sticky ovf cleared on accept).
- Backpressure: out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout; out_ready=1 -> in_ready rises the next cycle.
- Drive rst_n=0 for one cycle at iteration 20 of a conversion of 12345 -> the following cycle shows IDLE with all outputs zero. A new conversion of 42 then returns 0x...042.
- With BCD_SIGNED_EN and BIN_W=8: in_bin=8'hFF -> out_neg=1, out_bcd=1. in_bin=8'h80 -> out_neg=1, out_bcd=128.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    typedef logic [3:0] bcd_digit_t;

    // Smallest digit count whose range 10^d exceeds the largest width-bit value.
    function automatic int digits_needed(input int width);
        logic [67:0] max_val;
        logic [67:0] p;
        int          d;
        max_val = (68'd1 << width) - 68'd1;
        p       = 68'd1;
        d       = 0;
        for (int i = 0; i < 21; i++) begin
            if (p <= max_val) begin
                p = p * 68'd10;
                d++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// One digit of the shift-and-add-3 correction: adds 3 when the digit is 5 or more.
module bcd_add3_cell
    import bcd_pkg::*;
(
    input  bcd_digit_t d,
    output bcd_digit_t q
);

    assign q = (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;

endmodule

// File: rtl/bcd_seq_conv.sv
// Iterative binary-to-BCD converter, one operand bit per clock, valid/ready on both sides.
// Build option BCD_SIGNED_EN: treat in_bin as two's-complement and report the sign on out_neg.
module bcd_seq_conv
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 36,
    parameter int DIGITS = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIN_W-1:0]    in_bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_ovf,
    output logic                out_neg,
    output bcd_state_t          dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
    // The producer holds its payload while valid && !ready; ready never depends on valid.

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    bcd_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] sreg;
    logic [BCD_W-1:0] dig;
    logic [BCD_W-1:0] adj;
    logic [BIN_W-1:0] load_val;
    logic             accept;

    assign accept = (state == IDLE) && in_valid && in_ready;

    for (genvar k = 0; k < DIGITS; k++) begin : g_cell
        bcd_add3_cell u_cell (
            .d (dig[4*k +: 4]),
            .q (adj[4*k +: 4])
        );
    end

`ifdef BCD_SIGNED_EN
    assign load_val = in_bin[BIN_W-1] ? (~in_bin + BIN_W'(1)) : in_bin;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_neg <= 1'b0;
        end else if (accept) begin
            out_neg <= in_bin[BIN_W-1];
        end
    end
`else
    assign load_val = in_bin;
    assign out_neg  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sreg      <= '0;
            dig       <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg     <= load_val;
                        dig      <= '0;
                        cnt      <= '0;
                        out_ovf  <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    // A 1 leaving the top digit means the value needs more digits.
                    dig  <= {adj[BCD_W-2:0], sreg[BIN_W-1]};
                    sreg <= {sreg[BIN_W-2:0], 1'b0};
                    if (adj[BCD_W-1]) begin
                        out_ovf <= 1'b1;
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign out_bcd   = dig;
    assign dbg_state = state;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Scoreboard bench for bcd_seq_conv: a default 36-bit instance and a narrow 8-bit instance.
module tb_bcd_seq_conv;
    import bcd_pkg::*;

    localparam int A_W = 36;
    localparam int A_D = 11;
    localparam int B_W = 8;
`ifdef BCD_SIGNED_EN
    localparam int B_D = 3;
`else
    localparam int B_D = 2;
`endif

    logic clk;
    logic rst_n;

    logic             a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf, a_out_neg;
    logic [A_W-1:0]   a_in_bin;
    logic [4*A_D-1:0] a_out_bcd;
    bcd_state_t       a_state;

    logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf, b_out_neg;
    logic [B_W-1:0]   b_in_bin;
    logic [4*B_D-1:0] b_out_bcd;
    bcd_state_t       b_state;

    logic [45:0] a_exp_q[$];
    logic [13:0] b_exp_q[$];
    int pass_cnt  = 0;
    int total_cnt = 0;

    bcd_seq_conv #(.BIN_W(A_W), .DIGITS(A_D)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bin(a_in_bin),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_bcd(a_out_bcd), .out_ovf(a_out_ovf), .out_neg(a_out_neg),
        .dbg_state(a_state)
    );

    bcd_seq_conv #(.BIN_W(B_W), .DIGITS(B_D)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bin(b_in_bin),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_bcd(b_out_bcd), .out_ovf(b_out_ovf), .out_neg(b_out_neg),
        .dbg_state(b_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // monitors: pop and compare on every output handshake
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            if (a_exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL a_unexpected: got result %0h required no output",
                         {a_out_neg, a_out_ovf, a_out_bcd});
            end else begin
                check("a_result", 64'({a_out_neg, a_out_ovf, a_out_bcd}), 64'(a_exp_q.pop_front()));
            end
        end
        if (rst_n && b_out_valid && b_out_ready) begin
            if (b_exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL b_unexpected: got result %0h required no output",
                         {b_out_neg, b_out_ovf, b_out_bcd});
            end else begin
                check("b_result", 64'({b_out_neg, b_out_ovf, 12'(b_out_bcd)}), 64'(b_exp_q.pop_front()));
            end
        end
    end

    // drivers: called and return at 1 time unit after a rising edge
    task automatic send_a(input logic [A_W-1:0] v, input logic [45:0] exp);
        int n = 0;
        while (!a_in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!a_in_ready) begin
            total_cnt++;
            $display("FAIL a_send_timeout: in_ready got 0 required 1");
        end else begin
            a_in_valid = 1'b1;
            a_in_bin   = v;
            a_exp_q.push_back(exp);
            @(posedge clk); #1;
            a_in_valid = 1'b0;
        end
    endtask

    task automatic send_b(input logic [B_W-1:0] v, input logic [13:0] exp);
        int n = 0;
        while (!b_in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!b_in_ready) begin
            total_cnt++;
            $display("FAIL b_send_timeout: in_ready got 0 required 1");
        end else begin
            b_in_valid = 1'b1;
            b_in_bin   = v;
            b_exp_q.push_back(exp);
            @(posedge clk); #1;
            b_in_valid = 1'b0;
        end
    endtask

    task automatic wait_a_valid(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk); #1; cycles++;
        end while (!a_out_valid && cycles < 100);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((a_exp_q.size() != 0 || b_exp_q.size() != 0) && n < limit) begin
            @(posedge clk); #1; n++;
        end
    endtask

    initial begin
        int cyc;
        rst_n       = 1'b0;
        a_in_valid  = 1'b0; a_in_bin = '0; a_out_ready = 1'b1;
        b_in_valid  = 1'b0; b_in_bin = '0; b_out_ready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("a_in_ready_in_reset", 64'(a_in_ready), 64'd0);
        check("b_in_ready_in_reset", 64'(b_in_ready), 64'd0);
        check("a_reset_outputs", 64'({a_out_valid, a_out_ovf, a_out_neg, a_out_bcd}), 64'd0);
        check("b_reset_outputs", 64'({b_out_valid, b_out_ovf, b_out_neg, b_out_bcd}), 64'd0);
        check("a_reset_state", 64'(a_state), 64'(IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("a_in_ready_after_reset", 64'(a_in_ready), 64'd1);
        check("b_in_ready_after_reset", 64'(b_in_ready), 64'd1);

        check("digits_needed_36", 64'(digits_needed(36)), 64'd11);
        check("digits_needed_8", 64'(digits_needed(8)), 64'd3);

        // narrow instance: overflow and sticky-ovf clearing
`ifdef BCD_SIGNED_EN
        send_b(8'hFF, {1'b1, 1'b0, 12'h001});
        send_b(8'h80, {1'b1, 1'b0, 12'h128});
        send_b(8'h63, {1'b0, 1'b0, 12'h099});
        send_b(8'h9D, {1'b1, 1'b0, 12'h099});
`else
        send_b(8'd255, {1'b0, 1'b1, 12'h055});
        send_b(8'd99,  {1'b0, 1'b0, 12'h099});
        send_b(8'd100, {1'b0, 1'b1, 12'h000});
        send_b(8'd7,   {1'b0, 1'b0, 12'h007});
`endif
        drain(200);

        // latency from acceptance edge
        send_a(36'd0, 46'd0);
        wait_a_valid(cyc);
        check("a_latency", 64'(cyc), 64'd36);

`ifdef BCD_SIGNED_EN
        send_a(36'hFFFFFFFFF, {1'b1, 1'b0, 44'h00000000001});
`else
        send_a(36'hFFFFFFFFF, {1'b0, 1'b0, 44'h68719476735});
`endif
        send_a(36'd10000000000, {2'b00, 44'h10000000000});
        send_a(36'd1000000,     {2'b00, 44'h00001000000});

        // in_valid while busy is ignored and not queued
        send_a(36'd34359738367, {2'b00, 44'h34359738367});
        a_in_valid = 1'b1;
        a_in_bin   = 36'd999;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("a_in_ready_busy", 64'(a_in_ready), 64'd0);
        end
        a_in_valid = 1'b0;
        drain(200);

        // backpressure
        a_out_ready = 1'b0;
        send_a(36'd987654321, {2'b00, 44'h00987654321});
        wait_a_valid(cyc);
        check("a_bp_latency", 64'(cyc), 64'd36);
        for (int i = 0; i < 10; i++) begin
            check("a_bp_hold", 64'({a_out_valid, a_in_ready, a_out_ovf, a_out_bcd}),
                  64'({1'b1, 1'b0, 1'b0, 44'h00987654321}));
            @(posedge clk); #1;
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        check("a_bp_release_in_ready", 64'(a_in_ready), 64'd1);
        check("a_bp_release_valid", 64'(a_out_valid), 64'd0);

        // reset in the middle of a conversion
        send_a(36'd12345, {2'b00, 44'h00000012345});
        repeat (19) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_exp_q.delete();
        check("a_midreset_state", 64'(a_state), 64'(IDLE));
        check("a_midreset_outputs", 64'({a_out_valid, a_in_ready, a_out_ovf, a_out_neg, a_out_bcd}), 64'd0);
        @(posedge clk); #1;
        check("a_midreset_in_ready", 64'(a_in_ready), 64'd1);
        send_a(36'd42, {2'b00, 44'h00000000042});

        drain(200);
        check("a_queue_drained", 64'(a_exp_q.size()), 64'd0);
        check("b_queue_drained", 64'(b_exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
